// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the two requesting pipeline stages
// (instruction fetch, load/store) and the byte-wide memory pins.
interface mem_arbiter_if;
    // Instruction-fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_inst;

    // Load/store data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_len;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;

    // Byte-serial memory bus
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic        busy;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_len, d_wdata, mem_din,
        output if_done, if_inst, d_done, d_rdata, mem_dout, mem_a, mem_wr, busy
    );

    // Requester and memory side
    modport master (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_len, d_wdata, mem_din,
        input  if_done, if_inst, d_done, d_rdata, mem_dout, mem_a, mem_wr, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing the 8-bit memory bus between instruction fetch
// and load/store. One 1/2/4-byte request at a time, data port has priority,
// reads reassembled little-endian, whole block frozen while rdy_in is low.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy_in,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  step, step_n;     // cycles spent in RD/WR since grant
    logic [1:0]  last, last_n;     // index of the final byte (N-1)
    logic [31:0] addr, addr_n;     // base address of the transfer
    logic [31:0] wdata, wdata_n;   // store data captured at grant
    logic        fetch, fetch_n;   // transfer belongs to the fetch port
    logic [31:0] rbuf, rbuf_n;     // read bytes captured so far

    logic [31:0] mem_a_n, if_inst_n, d_rdata_n;
    logic [7:0]  mem_dout_n;
    logic        mem_wr_n, if_done_n, d_done_n;

    logic        grant_d, grant_if;
    logic [1:0]  d_last;
    logic [2:0]  step_inc;
    logic [31:0] next_addr, merged;
    logic [7:0]  next_wbyte;

    // Next-state and next-output logic for the whole transfer sequencer.
    always_comb begin
        // NOTE: every target gets a default before the case so no path leaves one unassigned (no latches).
        state_n    = state;
        step_n     = step;
        last_n     = last;
        addr_n     = addr;
        wdata_n    = wdata;
        fetch_n    = fetch;
        rbuf_n     = rbuf;
        mem_a_n    = bus.mem_a;
        mem_dout_n = bus.mem_dout;
        mem_wr_n   = 1'b0;
        if_done_n  = 1'b0;
        d_done_n   = 1'b0;
        if_inst_n  = bus.if_inst;
        d_rdata_n  = bus.d_rdata;

        grant_d    = bus.d_req;
        grant_if   = !bus.d_req && bus.if_req && !bus.if_flush;
        d_last     = (bus.d_len == 2'd0) ? 2'd0 : (bus.d_len == 2'd1) ? 2'd1 : 2'd3;
        step_inc   = step + 3'd1;
        next_addr  = addr + {29'd0, step_inc};
        next_wbyte = 8'(wdata >> {step_inc[1:0], 3'b000});
        // Byte captured now belongs to the address issued two cycles earlier.
        merged     = rbuf | ({24'd0, bus.mem_din} << {step - 3'd1, 3'b000});

        case (state)
            IDLE: begin
                if (grant_d || grant_if) begin
                    addr_n  = grant_d ? bus.d_addr : bus.if_addr;
                    last_n  = grant_d ? d_last : 2'd3;
                    wdata_n = bus.d_wdata;
                    fetch_n = grant_if;
                    step_n  = 3'd0;
                    rbuf_n  = 32'd0;
                    mem_a_n = addr_n;
                    if (grant_d && bus.d_we) begin
                        state_n    = WR;
                        mem_wr_n   = 1'b1;
                        mem_dout_n = bus.d_wdata[7:0];
                    end else begin
                        state_n = RD;
                    end
                end
            end
            RD: begin
                if (fetch && bus.if_flush) begin
                    state_n = IDLE;
                    step_n  = 3'd0;
                end else begin
                    if (step != 3'd0)
                        rbuf_n = merged;
                    if (step == {1'b0, last} + 3'd1) begin
                        state_n = DONE;
                        step_n  = 3'd0;
                        if (fetch) begin
                            if_done_n = 1'b1;
                            if_inst_n = merged;
                        end else begin
                            d_done_n  = 1'b1;
                            d_rdata_n = merged;
                        end
                    end else begin
                        step_n = step_inc;
                        if (step < {1'b0, last})
                            mem_a_n = next_addr;
                    end
                end
            end
            WR: begin
                if (step == {1'b0, last}) begin
                    state_n  = DONE;
                    step_n   = 3'd0;
                    d_done_n = 1'b1;
                end else begin
                    step_n     = step_inc;
                    mem_a_n    = next_addr;
                    mem_dout_n = next_wbyte;
                    mem_wr_n   = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                step_n  = 3'd0;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register; held while rdy_in is low.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees only pre-edge values.
        if (rst)
            state <= IDLE;
        else if (rdy_in)
            state <= state_n;
    end

    // Datapath and registered outputs; held while rdy_in is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            step         <= 3'd0;
            last         <= 2'd0;
            addr         <= 32'd0;
            wdata        <= 32'd0;
            fetch        <= 1'b0;
            rbuf         <= 32'd0;
            bus.mem_a    <= 32'd0;
            bus.mem_dout <= 8'd0;
            bus.mem_wr   <= 1'b0;
            bus.if_done  <= 1'b0;
            bus.d_done   <= 1'b0;
            bus.if_inst  <= 32'd0;
            bus.d_rdata  <= 32'd0;
            bus.busy     <= 1'b0;
        end else if (rdy_in) begin
            step         <= step_n;
            last         <= last_n;
            addr         <= addr_n;
            wdata        <= wdata_n;
            fetch        <= fetch_n;
            rbuf         <= rbuf_n;
            bus.mem_a    <= mem_a_n;
            bus.mem_dout <= mem_dout_n;
            bus.mem_wr   <= mem_wr_n;
            bus.if_done  <= if_done_n;
            bus.d_done   <= d_done_n;
            bus.if_inst  <= if_inst_n;
            bus.d_rdata  <= d_rdata_n;
            bus.busy     <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a byte memory with 2-cycle reads paused
// by rdy_in, and a transaction-level reference (byte image + latency rules).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rdy_in;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk    (clk),
        .rst    (rst),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory: 1 KiB backing store, content scrambled by the full address so
    // aliased addresses still read back different bytes.
    bit [7:0] mem_img [1024];
    bit [7:0] ref_img [1024];

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wr_log [$];

    function automatic logic [7:0] scramble(input logic [31:0] a);
        return a[31:24] ^ a[23:16] ^ a[15:8] ^ (a[7:0] * 8'd37) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return ref_img[a[9:0]] ^ scramble(a);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int k = 0; k < n; k++)
            w = w | ({24'd0, byte_at(a + 32'(k))} << (8 * k));
        return w;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [7:0] d);
        ref_img[a[9:0]] = d ^ scramble(a);
    endtask

    // Memory model: address sampled at a ready edge, data returned on the
    // next one; writes land on ready edges with mem_wr high.
    always @(posedge clk) begin
        if (rdy_in) begin
            bus.mem_din <= mem_img[bus.mem_a[9:0]] ^ scramble(bus.mem_a);
            if (bus.mem_wr) begin
                mem_img[bus.mem_a[9:0]] <= bus.mem_dout ^ scramble(bus.mem_a);
                wr_log.push_back('{bus.mem_a, bus.mem_dout});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick_rdy(input int mode, input int cyc);
        case (mode)
            1:       return ($urandom_range(0, 3) != 0);
            2:       return !(cyc >= 2 && cyc < 5);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_mem_a"},    bus.mem_a,    32'd0);
        check({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'd0);
        check({tag, "_mem_wr"},   32'(bus.mem_wr),   32'd0);
        check({tag, "_if_done"},  32'(bus.if_done),  32'd0);
        check({tag, "_d_done"},   32'(bus.d_done),   32'd0);
        check({tag, "_if_inst"},  bus.if_inst,  32'd0);
        check({tag, "_d_rdata"},  bus.d_rdata,  32'd0);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
    endtask

    task automatic check_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (mem_img[i] !== ref_img[i]) bad++;
        check("mem_image", bad, 0);
    endtask

    // Wait with rdy_in as currently driven until the selected done appears.
    task automatic wait_done(input bit sel_fetch, output int cyc, output bit other);
        bit seen;
        seen = 1'b0;
        other = 1'b0;
        cyc = 0;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            seen = sel_fetch ? bus.if_done : bus.d_done;
            if ((sel_fetch ? bus.d_done : bus.if_done) == 1'b1) other = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    // One complete transfer with reference checks on latency, data, bus writes.
    task automatic run_xfer(input bit is_fetch, input bit we, input logic [31:0] a,
                            input logic [1:0] len, input logic [31:0] wd, input int mode);
        int n, exp_lat, ready_edges, cyc, hold;
        logic [31:0] exp_data, other_before, got;
        bit seen, other_seen;
        n = (is_fetch || len[1]) ? 4 : ((len == 2'd1) ? 2 : 1);
        exp_lat = we ? n : n + 1;
        exp_data = word_at(a, n);
        other_before = is_fetch ? bus.d_rdata : bus.if_inst;
        wr_log.delete();

        rdy_in = 1'b1;
        if (is_fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = a;
        end else begin
            bus.d_req   = 1'b1;
            bus.d_we    = we;
            bus.d_addr  = a;
            bus.d_len   = len;
            bus.d_wdata = wd;
        end
        tick();
        check("grant_busy", 32'(bus.busy), 32'd1);
        check("byte0_addr", bus.mem_a, a);

        ready_edges = 0;
        cyc = 0;
        seen = 1'b0;
        other_seen = 1'b0;
        while (!seen && cyc < 100) begin
            rdy_in = pick_rdy(mode, cyc);
            tick();
            cyc++;
            if (rdy_in) ready_edges++;
            seen = is_fetch ? bus.if_done : bus.d_done;
            if ((is_fetch ? bus.d_done : bus.if_done) == 1'b1) other_seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", ready_edges, exp_lat);
        if (mode == 2) check("stall_cycles", cyc, exp_lat + 3);
        check("other_done", 32'(other_seen), 32'd0);

        if (is_fetch) bus.if_req = 1'b0;
        else          bus.d_req  = 1'b0;

        if (!we) begin
            got = is_fetch ? bus.if_inst : bus.d_rdata;
            check(is_fetch ? "fetch_data" : "load_data", got, exp_data);
        end
        check("other_held", is_fetch ? bus.d_rdata : bus.if_inst, other_before);

        // done must survive stalled cycles and vanish after one ready cycle
        hold = 0;
        do begin
            rdy_in = (hold >= 8) ? 1'b1 : pick_rdy((mode == 1) ? 1 : 0, 0);
            tick();
            hold++;
            if (!rdy_in)
                check("done_hold", 32'(is_fetch ? bus.if_done : bus.d_done), 32'd1);
        end while (!rdy_in);
        check("done_pulse_end", 32'(is_fetch ? bus.if_done : bus.d_done), 32'd0);
        check("back_idle", 32'(bus.busy), 32'd0);

        check("write_count", wr_log.size(), we ? n : 0);
        if (we) begin
            for (int k = 0; k < n; k++) begin
                if (k < wr_log.size()) begin
                    check("wr_addr", wr_log[k].a, a + 32'(k));
                    check("wr_data", 32'(wr_log[k].d), 32'(wd[8*k +: 8]));
                end
                ref_write(a + 32'(k), wd[8*k +: 8]);
            end
            check_image();
        end
    endtask

    initial begin
        int cyc;
        bit oth;
        int kind;
        logic [31:0] a, prev;

        rst = 1'b1;
        rdy_in = 1'b1;
        bus.if_req = 1'b0;  bus.if_addr = 32'd0; bus.if_flush = 1'b0;
        bus.d_req = 1'b0;   bus.d_we = 1'b0;     bus.d_addr = 32'd0;
        bus.d_len = 2'd0;   bus.d_wdata = 32'd0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Program a word, then fetch it
        run_xfer(1'b0, 1'b1, 32'h100, 2'd2, 32'h0000_0513, 0);
        run_xfer(1'b1, 1'b0, 32'h100, 2'd2, 32'd0, 0);
        check("fetch_0x100", bus.if_inst, 32'h0000_0513);

        // Half store touches only two bytes
        run_xfer(1'b0, 1'b1, 32'h30, 2'd1, 32'hAABB_CCDD, 0);
        run_xfer(1'b0, 1'b0, 32'h30, 2'd2, 32'd0, 0);
        check("half_store_lo", 32'(bus.d_rdata[15:0]), 32'h0000_CCDD);

        // Same fetch with a 3-cycle stall mid transfer
        run_xfer(1'b1, 1'b0, 32'h100, 2'd2, 32'd0, 2);
        check("stall_fetch", bus.if_inst, 32'h0000_0513);

        // Address wrap-around at the top of the space
        run_xfer(1'b0, 1'b1, 32'hFFFF_FFFE, 2'd2, 32'h1122_3344, 0);
        run_xfer(1'b0, 1'b0, 32'hFFFF_FFFF, 2'd1, 32'd0, 0);
        check("wrap_half", bus.d_rdata, 32'h0000_2233);

        // Simultaneous requests: data first, fetch after DONE -> IDLE
        rdy_in = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h140;
        bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.d_len = 2'd2;
        tick();
        check("prio_addr", bus.mem_a, 32'h2000);
        wait_done(1'b0, cyc, oth);
        check("prio_d_lat", cyc, 5);
        check("prio_no_if_done", 32'(oth), 32'd0);
        check("prio_d_rdata", bus.d_rdata, word_at(32'h2000, 4));
        bus.d_req = 1'b0;
        tick();
        check("prio_back_idle", 32'(bus.busy), 32'd0);
        tick();
        check("prio_fetch_addr", bus.mem_a, 32'h140);
        wait_done(1'b1, cyc, oth);
        check("prio_if_lat", cyc, 5);
        check("prio_if_inst", bus.if_inst, word_at(32'h140, 4));
        bus.if_req = 1'b0;
        tick();
        check("prio_end_idle", 32'(bus.busy), 32'd0);

        // Fetch aborted after byte 1 is captured
        prev = bus.if_inst;
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        repeat (4) tick();
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        tick();
        check("flush_idle", 32'(bus.busy), 32'd0);
        check("flush_no_done", 32'(bus.if_done), 32'd0);
        check("flush_inst_held", bus.if_inst, prev);
        bus.if_flush = 1'b0;
        tick();
        check("flush_no_done2", 32'(bus.if_done), 32'd0);
        run_xfer(1'b1, 1'b0, 32'h204, 2'd2, 32'd0, 0);

        // Flush in IDLE blocks the fetch grant but not a data grant
        bus.if_req = 1'b1; bus.if_addr = 32'h300; bus.if_flush = 1'b1;
        tick();
        check("flush_idle_block", 32'(bus.busy), 32'd0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_len = 2'd0;
        tick();
        check("flush_data_grant", 32'(bus.busy), 32'd1);
        check("flush_data_addr", bus.mem_a, 32'h40);
        bus.if_req = 1'b0;
        wait_done(1'b0, cyc, oth);
        check("flush_data_lat", cyc, 2);
        check("flush_data_byte", bus.d_rdata, word_at(32'h40, 1));
        bus.d_req = 1'b0; bus.if_flush = 1'b0;
        tick();
        check("flush_data_idle", 32'(bus.busy), 32'd0);

        // Reset while byte 2 of a word store is on the bus
        wr_log.delete();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_len = 2'd2;
        bus.d_wdata = 32'hDEAD_BEEF;
        repeat (3) tick();
        check("rstwr_addr", bus.mem_a, 32'h82);
        check("rstwr_wr", 32'(bus.mem_wr), 32'd1);
        rst = 1'b1;
        tick();
        check_idle("rst_mid_wr");
        rst = 1'b0; bus.d_req = 1'b0;
        tick();
        check("rstwr_no_done", 32'(bus.d_done), 32'd0);
        check("rstwr_idle", 32'(bus.busy), 32'd0);
        check("rstwr_partial", wr_log.size(), 3);
        ref_write(32'h80, 8'hEF);
        ref_write(32'h81, 8'hBE);
        ref_write(32'h82, 8'hAD);
        check_image();

        // Randomized mix with random rdy_in stalls
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2:       a = 32'h0003_0000 | 32'($urandom_range(0, 255));
                default: a = 32'($urandom_range(0, 1023));
            endcase
            run_xfer(kind == 0, kind == 2, a, 2'($urandom_range(0, 3)), $urandom, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
